// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 stream padder: FSM states, the padding
// marker byte, the standard SHA-256/SHA-512 parameter sets and width helpers.
package sha_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    PAD   = 2'd1,
    LEN   = 2'd2
  } sha_state_e;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam int SHA256_WORD_W      = 32'sd32;
  localparam int SHA256_BLOCK_WORDS = 32'sd16;
  localparam int SHA256_LEN_W       = 32'sd64;

  localparam int SHA512_WORD_W      = 32'sd64;
  localparam int SHA512_BLOCK_WORDS = 32'sd16;
  localparam int SHA512_LEN_W       = 32'sd128;

  // Index width able to address n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Number of byte lanes in a word.
  function automatic int lanes_of(input int word_w);
    return word_w / 32'sd8;
  endfunction

endpackage

// File: rtl/sha_byte_lane_packer.sv
// Byte-to-word packer: keeps the lane counter and the partially filled word,
// and owns the output holding register with its valid/ready handshake.
// The controlling FSM either inserts a byte (optionally as the final byte,
// with the padding marker placed behind it) or loads a complete word.
module sha_byte_lane_packer
  import sha_pkg::*;
#(
  parameter int WORD_W = SHA256_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_en_i,
  input  logic [7:0]        ins_byte_i,
  input  logic              flush_i,
  input  logic              marker_i,
  input  logic              load_en_i,
  input  logic [WORD_W-1:0] load_word_i,
  input  logic              block_last_i,
  input  logic              msg_last_i,
  input  logic              out_ready_i,
  output logic              load_ok_o,
  output logic              push_o,
  output logic              lane_top_o,
  output logic              word_valid_o,
  output logic [WORD_W-1:0] word_o,
  output logic              block_last_o,
  output logic              msg_last_o
);

  localparam int LANES  = lanes_of(WORD_W);
  localparam int LANE_W = idx_width(LANES);
  localparam logic [LANE_W-1:0] LANE_TOP = LANE_W'(LANES - 32'sd1);
  localparam logic [LANE_W-1:0] LANE_ONE = {{(LANE_W-1){1'b0}}, 1'b1};

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              bl_q, bl_d;
  logic              ml_q, ml_d;

  logic [WORD_W-1:0] byte_word_s;
  logic              marker_sel_s;
  logic              byte_push_s;

  // Merge the incoming byte (and the marker behind a final byte) into the partial word.
  always_comb begin
    marker_sel_s = flush_i && marker_i && (lane_q != LANE_TOP);
    byte_word_s  = acc_q;
    for (int l = 0; l < LANES; l++) begin
      byte_word_s[(LANES-1-l)*8 +: 8] =
        (lane_q == LANE_W'(l)) ? ins_byte_i :
        (marker_sel_s && ((lane_q + LANE_ONE) == LANE_W'(l))) ? PAD_BYTE :
        acc_q[(LANES-1-l)*8 +: 8];
    end
  end

  // Handshake status and next-state of the lane accumulator and output register.
  always_comb begin
    lane_top_o  = (lane_q == LANE_TOP);
    load_ok_o   = !valid_q || out_ready_i;
    byte_push_s = ins_en_i && (lane_top_o || flush_i);
    push_o      = byte_push_s || load_en_i;

    if (byte_push_s) begin
      acc_d  = '0;
      lane_d = '0;
    end else if (ins_en_i) begin
      acc_d  = byte_word_s;
      lane_d = lane_q + LANE_ONE;
    end else begin
      acc_d  = acc_q;
      lane_d = lane_q;
    end

    if (push_o) begin
      valid_d = 1'b1;
      word_d  = load_en_i ? load_word_i : byte_word_s;
      bl_d    = block_last_i;
      ml_d    = msg_last_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
      word_d  = word_q;
      bl_d    = 1'b0;
      ml_d    = 1'b0;
    end else begin
      valid_d = valid_q;
      word_d  = word_q;
      bl_d    = bl_q;
      ml_d    = ml_q;
    end
  end

  // Accumulator, lane counter and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      word_q  <= '0;
      bl_q    <= 1'b0;
      ml_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      bl_q    <= bl_d;
      ml_q    <= ml_d;
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;
  assign block_last_o = bl_q;
  assign msg_last_o   = ml_q;

endmodule

// File: rtl/sha_stream_padder.sv
// SHA-2 stream padder: packs a framed byte stream into big-endian words and
// appends the SHA-2 padding (0x80 marker, zero fill, message bit length) so
// the hash core receives complete BLOCK_WORDS-word blocks.
// Optional feature macro SHA_PAD_BYPASS_EN adds pad_bypass_in, which lets a
// message pass through unpadded (last partial word zero-filled).
module sha_stream_padder
  import sha_pkg::*;
#(
  parameter int WORD_W      = SHA256_WORD_W,
  parameter int BLOCK_WORDS = SHA256_BLOCK_WORDS,
  parameter int LEN_W       = SHA256_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SHA_PAD_BYPASS_EN
  input  logic              pad_bypass_in,
`endif
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_last_in,
  output logic              byte_ready_out,
  output logic              word_valid_out,
  output logic [WORD_W-1:0] word_out,
  input  logic              word_ready_in,
  output logic              block_last_out,
  output logic              msg_last_out
);

  localparam int LEN_WORDS = LEN_W / WORD_W;
  localparam int WIDX_W    = idx_width(BLOCK_WORDS);
  localparam int LIDX_W    = idx_width(LEN_WORDS);
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(BLOCK_WORDS - 32'sd1);
  localparam logic [WIDX_W-1:0] WIDX_ONE  = {{(WIDX_W-1){1'b0}}, 1'b1};
  localparam logic [WIDX_W-1:0] PAD_LIMIT = WIDX_W'(BLOCK_WORDS - LEN_WORDS);
  localparam logic [LIDX_W-1:0] LIDX_LAST = LIDX_W'(LEN_WORDS - 32'sd1);
  localparam logic [LIDX_W-1:0] LIDX_ONE  = {{(LIDX_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  BYTE_BITS = {{(LEN_W-4){1'b0}}, 4'd8};
  localparam logic [WORD_W-1:0] MARKER_WORD = {PAD_BYTE, {(WORD_W-8){1'b0}}};

  sha_state_e        state_q, state_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [LEN_W-1:0]  bitcnt_q, bitcnt_d;
  logic [LIDX_W-1:0] lidx_q, lidx_d;
  logic              mark_pend_q, mark_pend_d;

  logic              load_ok_s;
  logic              push_s;
  logic              lane_top_s;
  logic              ins_en_s;
  logic              flush_s;
  logic              marker_s;
  logic              load_en_s;
  logic [WORD_W-1:0] load_word_s;
  logic              flag_bl_s;
  logic              flag_ml_s;
  logic [WIDX_W-1:0] widx_inc_s;
  logic [WORD_W-1:0] len_word_s;
  logic              byp_s;

`ifdef SHA_PAD_BYPASS_EN
  logic first_q, first_d;
  logic bypass_q, bypass_d;

  // Bypass decision is taken from the first byte and held for the whole message.
  always_comb begin
    byp_s = first_q ? pad_bypass_in : bypass_q;
    if (ins_en_s) begin
      first_d = flush_s;
    end else begin
      first_d = first_q;
    end
    if (ins_en_s && first_q) begin
      bypass_d = pad_bypass_in;
    end else begin
      bypass_d = bypass_q;
    end
  end

  // First-byte tracker and sampled bypass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q  <= 1'b1;
      bypass_q <= 1'b0;
    end else begin
      first_q  <= first_d;
      bypass_q <= bypass_d;
    end
  end
`else
  assign byp_s = 1'b0;
`endif

  // Word index after the current word, wrapping at the block end; length word select.
  always_comb begin
    widx_inc_s = (widx_q == WIDX_LAST) ? '0 : (widx_q + WIDX_ONE);
    len_word_s = '0;
    for (int k = 0; k < LEN_WORDS; k++) begin
      len_word_s = (lidx_q == LIDX_W'(k)) ? bitcnt_q[(LEN_WORDS-1-k)*WORD_W +: WORD_W]
                                          : len_word_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: a final byte either ends the message (bypass) or starts padding;
  // padding hands over to the length phase right after the word preceding PAD_LIMIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (ins_en_s && flush_s) begin
          if (byp_s) begin
            state_d = ACCUM;
          end else if (lane_top_s) begin
            state_d = PAD;
          end else if (widx_inc_s == PAD_LIMIT) begin
            state_d = LEN;
          end else begin
            state_d = PAD;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      PAD: begin
        if (load_ok_s && (widx_inc_s == PAD_LIMIT)) begin
          state_d = LEN;
        end else begin
          state_d = PAD;
        end
      end
      LEN: begin
        if (load_ok_s && (lidx_q == LIDX_LAST)) begin
          state_d = ACCUM;
        end else begin
          state_d = LEN;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // FSM outputs: byte acceptance in ACCUM, generated pad/length words otherwise.
  always_comb begin
    byte_ready_out = 1'b0;
    ins_en_s       = 1'b0;
    flush_s        = 1'b0;
    marker_s       = 1'b0;
    load_en_s      = 1'b0;
    load_word_s    = '0;
    flag_bl_s      = (widx_q == WIDX_LAST);
    flag_ml_s      = 1'b0;
    case (state_q)
      ACCUM: begin
        byte_ready_out = load_ok_s;
        ins_en_s       = byte_valid_in && load_ok_s;
        flush_s        = ins_en_s && byte_last_in;
        marker_s       = !byp_s;
        flag_bl_s      = (byp_s && flush_s) || (widx_q == WIDX_LAST);
        flag_ml_s      = byp_s && flush_s;
      end
      PAD: begin
        load_en_s   = load_ok_s;
        load_word_s = mark_pend_q ? MARKER_WORD : '0;
      end
      LEN: begin
        load_en_s   = load_ok_s;
        load_word_s = len_word_s;
        flag_ml_s   = (lidx_q == LIDX_LAST);
      end
      default: begin
        byte_ready_out = 1'b0;
      end
    endcase
  end

  // Next values of word index, bit counter, length-word index and pending marker.
  always_comb begin
    if (ins_en_s && flush_s && byp_s) begin
      widx_d = '0;
    end else if (push_s) begin
      widx_d = widx_inc_s;
    end else begin
      widx_d = widx_q;
    end

    if (ins_en_s) begin
      bitcnt_d = (flush_s && byp_s) ? '0 : (bitcnt_q + BYTE_BITS);
    end else if ((state_q == LEN) && load_ok_s && (lidx_q == LIDX_LAST)) begin
      bitcnt_d = '0;
    end else begin
      bitcnt_d = bitcnt_q;
    end

    if ((state_q == LEN) && load_ok_s) begin
      lidx_d = (lidx_q == LIDX_LAST) ? '0 : (lidx_q + LIDX_ONE);
    end else begin
      lidx_d = lidx_q;
    end

    // A final byte in the top lane leaves no room for the marker in that word.
    if (ins_en_s && flush_s && !byp_s && lane_top_s) begin
      mark_pend_d = 1'b1;
    end else if ((state_q == PAD) && load_ok_s) begin
      mark_pend_d = 1'b0;
    end else begin
      mark_pend_d = mark_pend_q;
    end
  end

  // Message bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q      <= '0;
      bitcnt_q    <= '0;
      lidx_q      <= '0;
      mark_pend_q <= 1'b0;
    end else begin
      widx_q      <= widx_d;
      bitcnt_q    <= bitcnt_d;
      lidx_q      <= lidx_d;
      mark_pend_q <= mark_pend_d;
    end
  end

  sha_byte_lane_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .ins_en_i     (ins_en_s),
    .ins_byte_i   (byte_in),
    .flush_i      (flush_s),
    .marker_i     (marker_s),
    .load_en_i    (load_en_s),
    .load_word_i  (load_word_s),
    .block_last_i (flag_bl_s),
    .msg_last_i   (flag_ml_s),
    .out_ready_i  (word_ready_in),
    .load_ok_o    (load_ok_s),
    .push_o       (push_s),
    .lane_top_o   (lane_top_s),
    .word_valid_o (word_valid_out),
    .word_o       (word_out),
    .block_last_o (block_last_out),
    .msg_last_o   (msg_last_out)
  );

endmodule
